// File: rtl/pa_riscv.sv
// pa_riscv: shared definitions for the multicycle RISC-V control path.
// Holds the controller state encoding, opcode constants, ALU operation
// codes, ALU decode classes and the datapath mux select encodings.
package pa_riscv;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_e;

    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    // How the ALU decoder should interpret funct3/funct7bit5.
    typedef enum logic [1:0] {
        ALU_CLS_ADD   = 2'd0,
        ALU_CLS_SUB   = 2'd1,
        ALU_CLS_RTYPE = 2'd2,
        ALU_CLS_ITYPE = 2'd3
    } alu_class_e;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps instruction fields to the ALU operation code.
// Ports:
//   i_funct3, i_funct7bit5 - instruction fields
//   i_class                - forced ADD/SUB, or R-type / I-type field decode
//   o_alu_op               - ALU operation code (pa_riscv ALU_*)
module alu_decoder
    import pa_riscv::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  alu_class_e i_class,
    output logic [3:0] o_alu_op
);

    always_comb begin
        o_alu_op = ALU_ADD;
        case (i_class)
            ALU_CLS_ADD: o_alu_op = ALU_ADD;
            ALU_CLS_SUB: o_alu_op = ALU_SUB;
            default: begin
                case (i_funct3)
                    // funct7bit5 selects SUB only for register-register ops;
                    // for immediates that bit belongs to the immediate.
                    3'b000:  o_alu_op = (i_class == ALU_CLS_RTYPE && i_funct7bit5) ? ALU_SUB : ALU_ADD;
                    3'b111:  o_alu_op = ALU_AND;
                    3'b110:  o_alu_op = ALU_OR;
                    3'b010:  o_alu_op = ALU_SLT;
                    default: o_alu_op = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_fsm.sv
// multicycle_fsm: control FSM for a multicycle RISC-V style datapath.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 once memory is ready
// DECODE   | compute branch/jump target, dispatch on opcode
// MEMADR   | compute load/store address rs1 + imm
// MEMREAD  | load access, wait for memory
// MEMWB    | write loaded data to register file
// MEMWRITE | store access, wait for memory
// EXECUTER | register-register ALU op
// EXECUTEI | register-immediate ALU op
// ALUWB    | write ALU result to register file
// BEQ      | compare rs1/rs2, take branch on zero
// JAL      | PC <- target, link value computed as old PC + 4
// ERROR    | illegal opcode trap, held until reset
//
// Ports: i_clk, i_arst (async active-high), instruction fields i_operand,
// i_funct3, i_funct7bit5; i_zeroFlag, i_memReady status inputs; write
// enables, mux selects, ALU op, debug state and illegal-instruction flag.
//
// Build option: MULTICYCLE_ILLEGAL_TRAP_EN - when defined, an unknown opcode
// traps into ERROR; otherwise it is skipped and o_illegalInstr is 0.
module multicycle_fsm
    import pa_riscv::*;
(
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic [6:0] i_operand,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  logic       i_zeroFlag,
    input  logic       i_memReady,
    output logic       o_pcWrite,
    output logic       o_irWrite,
    output logic       o_regWriteEn,
    output logic       o_memWriteEn,
    output logic       o_adrSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_resultSrc,
    output logic [3:0] o_aluLogicOperation,
    output logic [3:0] o_state,
    output logic       o_illegalInstr
);

    state_e     state_q, state_d;
    alu_class_e alu_cls;
    logic       pc_write, ir_write, reg_write, mem_write;

    alu_decoder u_alu_decoder (
        .i_funct3     (i_funct3),
        .i_funct7bit5 (i_funct7bit5),
        .i_class      (alu_cls),
        .o_alu_op     (o_aluLogicOperation)
    );

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        o_adrSrc    = ADR_PC;
        o_aluSrcA   = SRCA_PC;
        o_aluSrcB   = SRCB_RS2;
        o_resultSrc = RES_ALUOUT;
        alu_cls     = ALU_CLS_ADD;
        case (state_q)
            S_FETCH: begin
                o_aluSrcB   = SRCB_FOUR;
                o_resultSrc = RES_ALU;
                ir_write    = i_memReady;
                pc_write    = i_memReady;
                if (i_memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                o_aluSrcA = SRCA_OLDPC;
                o_aluSrcB = SRCB_IMM;
                case (i_operand)
                    OPC_LW, OPC_SW: state_d = S_MEMADR;
                    OPC_RTYPE:      state_d = S_EXECUTER;
                    OPC_ITYPE:      state_d = S_EXECUTEI;
                    OPC_BEQ:        state_d = S_BEQ;
                    OPC_JAL:        state_d = S_JAL;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:        state_d = S_ERROR;
`else
                    default:        state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                o_aluSrcA = SRCA_RS1;
                o_aluSrcB = SRCB_IMM;
                state_d   = (i_operand == OPC_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                o_adrSrc = ADR_ALUOUT;
                if (i_memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                o_resultSrc = RES_DATA;
                reg_write   = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                o_adrSrc  = ADR_ALUOUT;
                mem_write = 1'b1;
                if (i_memReady) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                o_aluSrcA = SRCA_RS1;
                o_aluSrcB = SRCB_RS2;
                alu_cls   = ALU_CLS_RTYPE;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                o_aluSrcA = SRCA_RS1;
                o_aluSrcB = SRCB_IMM;
                alu_cls   = ALU_CLS_ITYPE;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                o_aluSrcA = SRCA_RS1;
                o_aluSrcB = SRCB_RS2;
                alu_cls   = ALU_CLS_SUB;
                pc_write  = i_zeroFlag;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                o_aluSrcA = SRCA_OLDPC;
                o_aluSrcB = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces FETCH asynchronously, and FETCH would otherwise raise
    // irWrite/pcWrite when memory is ready, so the enables are gated here.
    assign o_pcWrite    = pc_write  & ~i_arst;
    assign o_irWrite    = ir_write  & ~i_arst;
    assign o_regWriteEn = reg_write & ~i_arst;
    assign o_memWriteEn = mem_write & ~i_arst;
    assign o_state      = state_q;

    // ERROR is only left through reset, so the state itself is the sticky flag.
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign o_illegalInstr = (state_q == S_ERROR);
`else
    assign o_illegalInstr = 1'b0;
`endif

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_arst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port i_operand, input, 7, opcode field of the instruction register.
REQ-004 SHALL have ports i_funct3 (input, 3) and i_funct7bit5 (input, 1), instruction fields for ALU decode.
REQ-005 SHALL have port i_zeroFlag, input, 1, ALU zero result.
REQ-006 SHALL have port i_memReady, input, 1, memory access complete this cycle.
REQ-007 SHALL have outputs o_pcWrite, o_irWrite, o_regWriteEn, o_memWriteEn, o_adrSrc (1 each): PC, IR, register-file and memory write enables; address mux select (0 = PC, 1 = ALU result register).
REQ-008 SHALL have outputs o_aluSrcA, o_aluSrcB, o_resultSrc (2 each) and o_aluLogicOperation (4): datapath mux selects and ALU operation code.
REQ-009 SHALL have output o_state, 4, current state encoding for debug.
REQ-010 SHALL have output o_illegalInstr, 1, sticky illegal-opcode flag (see Configuration).

Function
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ERROR.
REQ-012 FETCH: adrSrc=0, aluSrcA=00 (PC), aluSrcB=10 (const 4), op ADD, resultSrc=10; irWrite and pcWrite assert only when i_memReady=1; advance to DECODE only when i_memReady=1, else stay.
REQ-013 DECODE: aluSrcA=01 (old PC), aluSrcB=01 (imm), op ADD; next state by opcode: lw/sw -> MEMADR, R-type -> EXECUTER, I-type ALU -> EXECUTEI, beq -> BEQ, jal -> JAL, other -> illegal handling.
REQ-014 MEMADR: aluSrcA=10 (rs1), aluSrcB=01, op ADD; lw -> MEMREAD, sw -> MEMWRITE.
REQ-015 MEMREAD: adrSrc=1, resultSrc=00; hold until i_memReady=1, then MEMWB.
REQ-016 MEMWB: resultSrc=01 (read data), regWriteEn=1 for exactly one cycle; -> FETCH.
REQ-017 MEMWRITE: adrSrc=1, resultSrc=00, memWriteEn=1 while in state; hold until i_memReady=1, then FETCH.
REQ-018 EXECUTER: aluSrcA=10, aluSrcB=00, op decoded from funct3/funct7bit5 (000+b5=1 -> SUB, else ADD; 111 AND; 110 OR; 010 SLT); -> ALUWB.
REQ-019 EXECUTEI: aluSrcA=10, aluSrcB=01, op from funct3 only (funct7bit5 ignored); -> ALUWB.
REQ-020 ALUWB: resultSrc=00, regWriteEn=1 one cycle; -> FETCH.
REQ-021 BEQ: aluSrcA=10, aluSrcB=00, op SUB, resultSrc=00; pcWrite = i_zeroFlag; -> FETCH.
REQ-022 JAL: aluSrcA=01, aluSrcB=10, op ADD, resultSrc=00, pcWrite=1; -> ALUWB.
REQ-023 All outputs SHALL be combinational from state (plus i_memReady/i_zeroFlag where stated); unlisted enables 0, unlisted selects 0.
REQ-024 Instruction latency with i_memReady=1 throughout: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.

Reset
REQ-025 i_arst SHALL force state FETCH and clear o_illegalInstr immediately, regardless of clock.
REQ-026 While i_arst=1, all write enables SHALL be 0; reset mid-instruction aborts it with no further writes.

Configuration
REQ-027 Macro MULTICYCLE_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE -> ERROR; ERROR asserts all enables 0, o_illegalInstr=1, held until reset.
REQ-028 Macro undefined: unknown opcode in DECODE -> FETCH, ERROR unreachable, o_illegalInstr tied 0.

Structure
REQ-029 State enum, opcode constants and ALU operation codes SHALL live in pa_riscv; mux select encodings likewise.
REQ-030 Sub-module alu_decoder (funct3, funct7bit5, operand class -> aluLogicOperation) SHALL be instantiated once.

Verification
REQ-031 lw (0000011), memReady=1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; regWriteEn=1 only in MEMWB, resultSrc=01.
REQ-032 FETCH with memReady low 3 cycles -> irWrite/pcWrite 0, state FETCH; 4th cycle memReady=1 -> irWrite=1, DECODE next.
REQ-033 beq (1100011) zeroFlag=1 -> pcWrite=1 in BEQ, op SUB; zeroFlag=0 -> pcWrite=0.
REQ-034 R-type 0110011, funct3=000, b5=1 -> aluLogicOperation=SUB in EXECUTER; I-type 0010011 same fields -> ADD.
REQ-035 Opcode 1111111: macro defined -> ERROR, o_illegalInstr=1 until reset; undefined -> FETCH after DECODE.
REQ-036 i_arst asserted mid-MEMWRITE -> memWriteEn 0 same cycle, state FETCH after release.
